// File: rtl/tpu_pkg.sv
// Shared widths, FSM encoding and saturation limits for the systolic-array datapath blocks.
package tpu_pkg;
    localparam int ELEM_W    = 16;
    localparam int OUT_W     = 8;
    localparam int NUM_ELEMS = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    localparam logic [7:0] SAT_MAX = 8'h7F;
    localparam logic [7:0] SAT_MIN = 8'h80;
endpackage

// File: rtl/sat_clamp.sv
// Combinational clamp of one signed result element down to a signed output byte.
module sat_clamp
    import tpu_pkg::*;
#(
    parameter int IN_W  = tpu_pkg::ELEM_W,
    parameter int OUT_W = tpu_pkg::OUT_W
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);

    // The value fits iff the sign bit and every bit above the output MSB agree.
    function automatic logic [OUT_W-1:0] clamp(input logic signed [IN_W-1:0] v);
        logic [IN_W-OUT_W:0] upper;
        upper = v[IN_W-1:OUT_W-1];
        if (upper == '0 || upper == '1)
            return v[OUT_W-1:0];
        else if (v[IN_W-1])
            return OUT_W'(SAT_MIN);
        else
            return OUT_W'(SAT_MAX);
    endfunction

    assign dout = clamp(din);

endmodule

// File: rtl/result_streamer.sv
// Snapshots the 2x2 result matrix on load and drains it byte-by-byte over a valid/ready bus.
module result_streamer
    import tpu_pkg::*;
#(
    parameter int ELEM_W    = tpu_pkg::ELEM_W,
    parameter int NUM_ELEMS = tpu_pkg::NUM_ELEMS,
    parameter int OUT_W     = tpu_pkg::OUT_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load,
    input  logic                        sat_mode,
    input  logic [ELEM_W*NUM_ELEMS-1:0] results,
    input  logic                        out_ready,
    output logic [OUT_W-1:0]            out_data,
    output logic                        out_valid,
    output logic                        out_last,
    output logic                        busy,
    output logic                        done
);

    localparam int BPE      = ELEM_W / OUT_W;
    localparam int FULL_LEN = NUM_ELEMS * BPE;
    localparam int CNT_W    = (FULL_LEN > 1) ? $clog2(FULL_LEN) : 1;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   last_idx;
    logic               mode_q;
    logic [OUT_W-1:0]   frame_q [FULL_LEN];
    logic [OUT_W-1:0]   capture [FULL_LEN];
    logic [OUT_W-1:0]   clamped [NUM_ELEMS];

    for (genvar k = 0; k < NUM_ELEMS; k++) begin : g_clamp
        sat_clamp #(
            .IN_W (ELEM_W),
            .OUT_W(OUT_W)
        ) u_clamp (
            .din (results[k*ELEM_W +: ELEM_W]),
            .dout(clamped[k])
        );
    end

    // Both modes are flattened into one emission-ordered byte array so a single mux serves them.
    always_comb begin
        for (int j = 0; j < FULL_LEN; j++)
            capture[j] = '0;
        if (sat_mode) begin
            for (int k = 0; k < NUM_ELEMS; k++)
                capture[k] = clamped[k];
        end else begin
            for (int k = 0; k < NUM_ELEMS; k++)
                for (int b = 0; b < BPE; b++)
                    capture[k*BPE + b] = results[k*ELEM_W + (BPE-1-b)*OUT_W +: OUT_W];
        end
    end

    assign last_idx  = mode_q ? CNT_W'(NUM_ELEMS - 1) : CNT_W'(FULL_LEN - 1);
    assign busy      = (state == ST_STREAM);
    assign out_valid = busy;
    assign out_last  = busy && (cnt == last_idx);
    assign out_data  = busy ? frame_q[cnt] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            mode_q <= 1'b0;
            done   <= 1'b0;
            for (int j = 0; j < FULL_LEN; j++)
                frame_q[j] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        for (int j = 0; j < FULL_LEN; j++)
                            frame_q[j] <= capture[j];
                        mode_q <= sat_mode;
                        cnt    <= '0;
                        state  <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (out_ready) begin
                        if (cnt == last_idx) begin
                            cnt   <= '0;
                            state <= ST_IDLE;
                            done  <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_result_streamer.sv
// Directed bench for result_streamer: full/sat frames, backpressure, load-while-busy, reset abort, back-to-back.
module tb_result_streamer;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic        sat_mode;
    logic [63:0] results;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_last;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    logic [63:0] res_a;
    logic [7:0]  full_exp [8];
    logic [7:0]  sat_exp  [4];

    always #5 clk = ~clk;

    result_streamer dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .sat_mode (sat_mode),
        .results  (results),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_last (out_last),
        .busy     (busy),
        .done     (done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b1; sat_mode = 1'b0; results = res_a; out_ready = 1'b1;
        step();
        step();
        total++;
        if ({out_valid, out_last, busy, done, out_data} !== 12'h000) begin
            bad++;
            $display("FAIL reset_outputs got v=%b l=%b b=%b d=%b data=%h want all 0",
                     out_valid, out_last, busy, done, out_data);
        end
        rst = 1'b0; load = 1'b0;
        step();
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle_hold got v=%b b=%b want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_full_frame();
        results = res_a; sat_mode = 1'b0; out_ready = 1'b1; load = 1'b1;
        step();
        load = 1'b0;
        results = 64'h0;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || out_data !== full_exp[i] ||
                out_last !== (i == 7) || done !== 1'b0) begin
                bad++;
                $display("FAIL full_byte%0d got v=%b b=%b data=%h last=%b done=%b want v=1 b=1 data=%h last=%b done=0",
                         i, out_valid, busy, out_data, out_last, done, full_exp[i], (i == 7));
            end
            step();
        end
        total++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 8'h00) begin
            bad++;
            $display("FAIL full_done got done=%b v=%b b=%b data=%h want done=1 v=0 b=0 data=00",
                     done, out_valid, busy, out_data);
        end
        step();
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL full_after got done=%b b=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_sat_frame(input logic [63:0] res, input logic [7:0] e0,
                                  input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] exp_b [4];
        exp_b[0] = e0; exp_b[1] = e1; exp_b[2] = e2; exp_b[3] = e3;
        results = res; sat_mode = 1'b1; out_ready = 1'b1; load = 1'b1;
        step();
        load = 1'b0; sat_mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== exp_b[i] || out_last !== (i == 3)) begin
                bad++;
                $display("FAIL sat_byte%0d got v=%b data=%h last=%b want v=1 data=%h last=%b",
                         i, out_valid, out_data, out_last, exp_b[i], (i == 3));
            end
            step();
        end
        total++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL sat_done got done=%b v=%b want 1 0", done, out_valid);
        end
        step();
    endtask

    task automatic test_backpressure();
        int idx = 0;
        int cyc = 0;
        logic       stalled = 1'b0;
        logic [7:0] prev_data = 8'h00;
        logic       prev_last = 1'b0;
        results = res_a; sat_mode = 1'b0; load = 1'b1; out_ready = 1'b0;
        step();
        load = 1'b0;
        while (idx < 8 && cyc < 60) begin
            if (stalled) begin
                total++;
                if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
                    bad++;
                    $display("FAIL bp_stable cyc%0d got v=%b data=%h last=%b want v=1 data=%h last=%b",
                             cyc, out_valid, out_data, out_last, prev_data, prev_last);
                end
            end
            out_ready = !((cyc == 1) || (cyc == 2) || (cyc >= 5 && cyc <= 9));
            if (out_valid && out_ready) begin
                total++;
                if (out_data !== full_exp[idx] || out_last !== (idx == 7)) begin
                    bad++;
                    $display("FAIL bp_byte%0d got data=%h last=%b want data=%h last=%b",
                             idx, out_data, out_last, full_exp[idx], (idx == 7));
                end
                idx++;
            end
            stalled   = out_valid && !out_ready;
            prev_data = out_data;
            prev_last = out_last;
            cyc++;
            step();
        end
        total++;
        if (idx != 8) begin
            bad++;
            $display("FAIL bp_timeout got %0d bytes want 8", idx);
        end
        total++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_done got done=%b v=%b want 1 0", done, out_valid);
        end
        out_ready = 1'b1;
        step();
    endtask

    task automatic test_load_while_busy();
        int dones = 0;
        results = res_a; sat_mode = 1'b0; out_ready = 1'b1; load = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== full_exp[i] || out_last !== (i == 7)) begin
                bad++;
                $display("FAIL lwb_byte%0d got v=%b data=%h last=%b want v=1 data=%h last=%b",
                         i, out_valid, out_data, out_last, full_exp[i], (i == 7));
            end
            if (i == 3) begin
                load = 1'b1; sat_mode = 1'b1; results = {4{16'hAAAA}};
            end else begin
                load = 1'b0; sat_mode = 1'b0;
            end
            step();
        end
        for (int i = 0; i < 4; i++) begin
            if (done) dones++;
            if (i > 0) begin
                total++;
                if (out_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL lwb_idle cyc%0d got v=%b want 0", i, out_valid);
                end
            end
            step();
        end
        total++;
        if (dones != 1) begin
            bad++;
            $display("FAIL lwb_done_count got %0d want 1", dones);
        end
    endtask

    task automatic test_reset_mid_frame();
        results = res_a; sat_mode = 1'b0; out_ready = 1'b1; load = 1'b1;
        step();
        load = 1'b0;
        step();
        step();
        step();
        total++;
        if (out_data !== full_exp[3]) begin
            bad++;
            $display("FAIL rmf_pre got data=%h want %h", out_data, full_exp[3]);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if ({out_valid, out_last, busy, done, out_data} !== 12'h000) begin
            bad++;
            $display("FAIL rmf_outputs got v=%b l=%b b=%b d=%b data=%h want all 0",
                     out_valid, out_last, busy, done, out_data);
        end
        step();
        total++;
        if (done !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rmf_nodone got done=%b v=%b want 0 0", done, out_valid);
        end
        test_full_frame();
    endtask

    task automatic test_back_to_back();
        results = res_a; sat_mode = 1'b0; out_ready = 1'b1; load = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < 8; i++) step();
        total++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_gap got done=%b v=%b want 1 0", done, out_valid);
        end
        load = 1'b1; sat_mode = 1'b1;
        step();
        load = 1'b0; sat_mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== sat_exp[i] || out_last !== (i == 3) || done !== 1'b0) begin
                bad++;
                $display("FAIL b2b_byte%0d got v=%b data=%h last=%b done=%b want v=1 data=%h last=%b done=0",
                         i, out_valid, out_data, out_last, done, sat_exp[i], (i == 3));
            end
            step();
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL b2b_done got %b want 1", done);
        end
        step();
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; sat_mode = 1'b0; results = '0; out_ready = 1'b0;
        res_a = {16'h8001, 16'h007F, 16'hFF80, 16'h1234};
        full_exp[0] = 8'h12; full_exp[1] = 8'h34; full_exp[2] = 8'hFF; full_exp[3] = 8'h80;
        full_exp[4] = 8'h00; full_exp[5] = 8'h7F; full_exp[6] = 8'h80; full_exp[7] = 8'h01;
        sat_exp[0] = 8'h7F; sat_exp[1] = 8'h80; sat_exp[2] = 8'h7F; sat_exp[3] = 8'h80;

        test_reset();
        test_full_frame();
        test_sat_frame(res_a, 8'h7F, 8'h80, 8'h7F, 8'h80);
        test_sat_frame({16'hFF7F, 16'h0080, 16'h0000, 16'hFFFF}, 8'hFF, 8'h00, 8'h7F, 8'h80);
        test_backpressure();
        test_load_while_busy();
        test_reset_mid_frame();
        test_back_to_back();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
